mem_stage_sequencer: RTL and testbench

Multi-cycle controller for the MEM stage of the pipelined LC-3b datapath. It turns the decoded `mem_read`/`mem_write` control bits into data-cache request/response handshakes. For LDI/STI it runs the two-access indirect sequence: pointer fetch, then data access. While an access is outstanding it stalls the upstream pipeline, and it releases the stall for exactly one cycle when the MEM-stage result is ready.

---
 rtl/lc3b_types.sv | 34 +++
 rtl/mem_stage_sequencer.sv | 115 +++++++++++
 tb/tb_mem_stage_sequencer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types.
// Provides the word and opcode types, the opcode encodings, and the state
// encoding used by the MEM-stage memory sequencer.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [3:0]  lc3b_opcode;

  localparam lc3b_opcode op_br   = 4'b0000;
  localparam lc3b_opcode op_add  = 4'b0001;
  localparam lc3b_opcode op_ldb  = 4'b0010;
  localparam lc3b_opcode op_stb  = 4'b0011;
  localparam lc3b_opcode op_jsr  = 4'b0100;
  localparam lc3b_opcode op_and  = 4'b0101;
  localparam lc3b_opcode op_ldr  = 4'b0110;
  localparam lc3b_opcode op_str  = 4'b0111;
  localparam lc3b_opcode op_rti  = 4'b1000;
  localparam lc3b_opcode op_not  = 4'b1001;
  localparam lc3b_opcode op_ldi  = 4'b1010;
  localparam lc3b_opcode op_sti  = 4'b1011;
  localparam lc3b_opcode op_jmp  = 4'b1100;
  localparam lc3b_opcode op_shf  = 4'b1101;
  localparam lc3b_opcode op_lea  = 4'b1110;
  localparam lc3b_opcode op_trap = 4'b1111;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    PTR,
    IND,
    DONE
  } memseq_state_t;

endpackage

// File: rtl/mem_stage_sequencer.sv
// MEM-stage memory sequencer for the pipelined LC-3b.
// Converts the MEM-stage mem_read/mem_write control bits into data-cache
// request/response handshakes, running the two-access pointer/data sequence
// for LDI/STI, and holds the upstream pipeline while an access is in flight.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   valid_in        MEM stage holds a valid instruction
//   opcode          MEM-stage opcode
//   mem_read_in     control word mem_read
//   mem_write_in    control word mem_write
//   addr_in         effective address
//   dmem_resp       data-cache response pulse
//   dmem_rdata      data-cache read data (valid with dmem_resp)
//   dmem_read       data-cache read request
//   dmem_write      data-cache write request
//   dmem_address    data-cache address
//   rdata_out       captured load data, valid while done is high
//   stall           freeze IF/ID/EX/MEM pipeline registers
//   done            one-cycle completion pulse
module mem_stage_sequencer
  import lc3b_types::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_in,
  input  lc3b_opcode opcode,
  input  logic       mem_read_in,
  input  logic       mem_write_in,
  input  lc3b_word   addr_in,
  input  logic       dmem_resp,
  input  lc3b_word   dmem_rdata,
  output logic       dmem_read,
  output logic       dmem_write,
  output lc3b_word   dmem_address,
  output lc3b_word   rdata_out,
  output logic       stall,
  output logic       done
);

  memseq_state_t state, state_next;
  lc3b_word      ptr_reg, data_reg;

  logic mem_op, indirect, is_ldi;

  assign mem_op   = valid_in & (mem_read_in | mem_write_in);
  assign indirect = mem_op & ((opcode == op_ldi) | (opcode == op_sti));
  assign is_ldi   = (opcode == op_ldi);

  // Combinational so the pipeline is already frozen in the acceptance cycle;
  // released in DONE so the finished instruction advances.
  assign stall = mem_op & (state != DONE);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (mem_op) state_next = indirect ? PTR : ACCESS;
      ACCESS:  if (dmem_resp) state_next = DONE;
      PTR:     if (dmem_resp) state_next = IND;
      IND:     if (dmem_resp) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    dmem_read    = 1'b0;
    dmem_write   = 1'b0;
    dmem_address = '0;
    rdata_out    = '0;
    done         = 1'b0;
    unique case (state)
      ACCESS: begin
        dmem_address = addr_in;
        dmem_read    = mem_read_in;
        // Read wins if a control word ever sets both bits.
        dmem_write   = mem_write_in & ~mem_read_in;
      end
      PTR: begin
        dmem_address = addr_in;
        dmem_read    = 1'b1;
      end
      IND: begin
        dmem_address = ptr_reg;
        dmem_read    = is_ldi;
        dmem_write   = ~is_ldi;
      end
      DONE: begin
        done      = 1'b1;
        rdata_out = data_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr_reg  <= '0;
      data_reg <= '0;
    end else begin
      state <= state_next;
      if (dmem_resp) begin
        unique case (state)
          ACCESS: if (mem_read_in) data_reg <= dmem_rdata;
          // Pointers are word addresses; drop the byte bit.
          PTR:    ptr_reg <= {dmem_rdata[15:1], 1'b0};
          IND:    if (is_ldi) data_reg <= dmem_rdata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_sequencer.sv
module tb_mem_stage_sequencer;
  import lc3b_types::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_in = 1'b0;
  lc3b_opcode opcode = op_add;
  logic       mem_read_in = 1'b0;
  logic       mem_write_in = 1'b0;
  lc3b_word   addr_in = '0;
  logic       dmem_resp = 1'b0;
  lc3b_word   dmem_rdata = '0;
  logic       dmem_read, dmem_write, stall, done;
  lc3b_word   dmem_address, rdata_out;

  mem_stage_sequencer dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .opcode(opcode),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .addr_in(addr_in),
    .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata), .dmem_read(dmem_read),
    .dmem_write(dmem_write), .dmem_address(dmem_address), .rdata_out(rdata_out),
    .stall(stall), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Cache model + activity counters, sampled 1 time unit after each falling edge.
  lc3b_word mem [lc3b_word];
  int       cyc, stall_cnt, rd_cnt, wr_cnt, both_cnt, done_cnt, done_cyc;
  lc3b_word done_data;
  int       wait_cfg = 0;
  int       wait_n = 0;
  logic     manual = 1'b0;
  logic     manual_resp = 1'b0;
  lc3b_word log_addr[$];
  logic     log_wr[$];

  always @(negedge clk) begin
    #1;
    cyc++;
    if (stall) stall_cnt++;
    if (dmem_read) rd_cnt++;
    if (dmem_write) wr_cnt++;
    if (dmem_read && dmem_write) both_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      done_data = rdata_out;
    end
    if (manual) begin
      dmem_resp = manual_resp;
      wait_n = 0;
    end else begin
      dmem_resp = 1'b0;
      if (dmem_read || dmem_write) begin
        if (wait_n == wait_cfg) begin
          dmem_resp = 1'b1;
          wait_n = 0;
          log_addr.push_back(dmem_address);
          log_wr.push_back(dmem_write);
          dmem_rdata = mem.exists(dmem_address) ? mem[dmem_address] : 16'h0000;
        end else begin
          wait_n++;
        end
      end else begin
        wait_n = 0;
      end
    end
  end

  task automatic clear_stats();
    cyc = 0; stall_cnt = 0; rd_cnt = 0; wr_cnt = 0; both_cnt = 0;
    done_cnt = 0; done_cyc = 0; done_data = '0;
    log_addr.delete(); log_wr.delete();
  endtask

  // Called at a falling edge: present an op for the next cycles.
  task automatic start_op(input lc3b_opcode op, input logic rd, input logic wr,
                          input lc3b_word a, input int w);
    opcode = op; mem_read_in = rd; mem_write_in = wr; addr_in = a;
    valid_in = 1'b1; wait_cfg = w;
    clear_stats();
  endtask

  task automatic wait_done(input string name);
    do @(negedge clk); while (done_cnt == 0 && cyc < 60);
    total++;
    if (done_cnt == 0) begin
      bad++;
      $display("FAIL %s timeout: no done after %0d cycles, required done", name, cyc);
    end
  endtask

  task automatic idle_inputs();
    valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0; opcode = op_add;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    total++;
    if ({dmem_read, dmem_write, done, stall} !== 4'b0000 || dmem_address !== 16'h0 || rdata_out !== 16'h0) begin
      bad++;
      $display("FAIL reset_outputs: rd=%b wr=%b done=%b stall=%b addr=%h rdata=%h, required all 0",
               dmem_read, dmem_write, done, stall, dmem_address, rdata_out);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ldr();
    mem[16'h3000] = 16'hBEEF;
    start_op(op_ldr, 1'b1, 1'b0, 16'h3000, 2);
    wait_done("ldr");
    idle_inputs();
    repeat (2) @(negedge clk);
    total++;
    if (rd_cnt !== 3 || wr_cnt !== 0) begin
      bad++; $display("FAIL ldr_req: rd=%0d wr=%0d, required rd=3 wr=0", rd_cnt, wr_cnt);
    end
    total++;
    if (stall_cnt !== 4) begin
      bad++; $display("FAIL ldr_stall: got %0d, required 4", stall_cnt);
    end
    total++;
    if (done_cyc !== 5 || done_cnt !== 1 || done_data !== 16'hBEEF) begin
      bad++; $display("FAIL ldr_done: cyc=%0d cnt=%0d data=%h, required cyc=5 cnt=1 data=beef",
                      done_cyc, done_cnt, done_data);
    end
    total++;
    if (log_addr.size() !== 1 || log_addr[0] !== 16'h3000) begin
      bad++; $display("FAIL ldr_addr: n=%0d, required single access at 3000", log_addr.size());
    end
  endtask

  task automatic test_str_zero_wait();
    start_op(op_str, 1'b0, 1'b1, 16'h4002, 0);
    wait_done("str");
    idle_inputs();
    repeat (2) @(negedge clk);
    total++;
    if (wr_cnt !== 1 || rd_cnt !== 0) begin
      bad++; $display("FAIL str_req: rd=%0d wr=%0d, required rd=0 wr=1", rd_cnt, wr_cnt);
    end
    total++;
    if (done_cyc !== 3 || stall_cnt !== 2) begin
      bad++; $display("FAIL str_timing: done_cyc=%0d stall=%0d, required 3 and 2", done_cyc, stall_cnt);
    end
    total++;
    if (log_addr.size() !== 1 || log_addr[0] !== 16'h4002 || log_wr[0] !== 1'b1) begin
      bad++; $display("FAIL str_addr: n=%0d, required one write at 4002", log_addr.size());
    end
  endtask

  task automatic test_ldi();
    mem[16'h5000] = 16'h6001;
    mem[16'h6000] = 16'h1234;
    start_op(op_ldi, 1'b1, 1'b0, 16'h5000, 0);
    wait_done("ldi");
    idle_inputs();
    repeat (2) @(negedge clk);
    total++;
    if (log_addr.size() !== 2 || log_addr[0] !== 16'h5000 || log_addr[1] !== 16'h6000 ||
        log_wr[0] !== 1'b0 || log_wr[1] !== 1'b0) begin
      bad++; $display("FAIL ldi_seq: n=%0d, required reads at 5000 then 6000", log_addr.size());
    end
    total++;
    if (done_data !== 16'h1234 || done_cyc !== 4 || stall_cnt !== 3) begin
      bad++; $display("FAIL ldi_done: data=%h cyc=%0d stall=%0d, required 1234 4 3",
                      done_data, done_cyc, stall_cnt);
    end
  endtask

  task automatic test_sti();
    mem[16'h5000] = 16'h7000;
    start_op(op_sti, 1'b0, 1'b1, 16'h5000, 1);
    wait_done("sti");
    idle_inputs();
    repeat (2) @(negedge clk);
    total++;
    if (log_addr.size() !== 2 || log_addr[0] !== 16'h5000 || log_wr[0] !== 1'b0 ||
        log_addr[1] !== 16'h7000 || log_wr[1] !== 1'b1) begin
      bad++; $display("FAIL sti_seq: n=%0d, required read 5000 then write 7000", log_addr.size());
    end
    total++;
    if (both_cnt !== 0 || rd_cnt !== 2 || wr_cnt !== 2) begin
      bad++; $display("FAIL sti_req: both=%0d rd=%0d wr=%0d, required 0 2 2", both_cnt, rd_cnt, wr_cnt);
    end
    total++;
    if (stall_cnt !== 5 || done_cyc !== 6) begin
      bad++; $display("FAIL sti_timing: stall=%0d done_cyc=%0d, required 5 6", stall_cnt, done_cyc);
    end
  endtask

  task automatic test_read_priority();
    mem[16'h2222] = 16'h00AA;
    start_op(op_ldr, 1'b1, 1'b1, 16'h2222, 0);
    wait_done("prio");
    idle_inputs();
    repeat (2) @(negedge clk);
    total++;
    if (rd_cnt !== 1 || wr_cnt !== 0 || done_data !== 16'h00AA) begin
      bad++; $display("FAIL read_priority: rd=%0d wr=%0d data=%h, required 1 0 00aa", rd_cnt, wr_cnt, done_data);
    end
  endtask

  task automatic test_back_to_back();
    mem[16'h3100] = 16'hAAAA;
    start_op(op_ldr, 1'b1, 1'b0, 16'h3100, 0);
    wait_done("b2b_first");
    total++;
    if (done_cyc !== 3 || done_data !== 16'hAAAA) begin
      bad++; $display("FAIL b2b_first: cyc=%0d data=%h, required 3 aaaa", done_cyc, done_data);
    end
    start_op(op_str, 1'b0, 1'b1, 16'h3102, 0);
    wait_done("b2b_second");
    idle_inputs();
    repeat (2) @(negedge clk);
    total++;
    if (done_cyc !== 3 || log_addr.size() !== 1 || log_addr[0] !== 16'h3102 || log_wr[0] !== 1'b1) begin
      bad++; $display("FAIL b2b_second: cyc=%0d n=%0d, required done cycle 3, one write at 3102",
                      done_cyc, log_addr.size());
    end
  endtask

  task automatic test_reset_mid_ind();
    mem[16'h5000] = 16'h6001;
    start_op(op_ldi, 1'b1, 1'b0, 16'h5000, 3);
    do @(negedge clk); while (cyc < 6);
    manual = 1'b1; manual_resp = 1'b0;
    #2;
    total++;
    if (dmem_read !== 1'b1 || dmem_address !== 16'h6000) begin
      bad++; $display("FAIL rst_mid_pre: rd=%b addr=%h, required 1 6000", dmem_read, dmem_address);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    manual_resp = 1'b1;
    dmem_rdata = 16'h9999;
    clear_stats();
    #2;
    total++;
    if ({dmem_read, dmem_write, done, stall} !== 4'b0000 || dmem_address !== 16'h0 || rdata_out !== 16'h0) begin
      bad++; $display("FAIL rst_mid_post: rd=%b wr=%b done=%b stall=%b addr=%h rdata=%h, required all 0",
                      dmem_read, dmem_write, done, stall, dmem_address, rdata_out);
    end
    @(negedge clk);
    manual_resp = 1'b0;
    repeat (3) @(negedge clk);
    manual = 1'b0;
    total++;
    if (done_cnt !== 0 || rd_cnt !== 0 || wr_cnt !== 0 || rdata_out !== 16'h0) begin
      bad++; $display("FAIL rst_late_resp: done=%0d rd=%0d wr=%0d rdata=%h, required 0 0 0 0",
                      done_cnt, rd_cnt, wr_cnt, rdata_out);
    end
  endtask

  task automatic test_non_mem_op();
    start_op(op_add, 1'b0, 1'b0, 16'h1234, 0);
    repeat (5) @(negedge clk);
    idle_inputs();
    @(negedge clk);
    total++;
    if (stall_cnt !== 0 || rd_cnt !== 0 || wr_cnt !== 0 || done_cnt !== 0) begin
      bad++; $display("FAIL non_mem_op: stall=%0d rd=%0d wr=%0d done=%0d, required all 0",
                      stall_cnt, rd_cnt, wr_cnt, done_cnt);
    end
  endtask

  initial begin
    clear_stats();
    @(negedge clk);
    test_reset();
    test_ldr();
    test_str_zero_wait();
    test_ldi();
    test_sti();
    test_read_priority();
    test_back_to_back();
    test_reset_mid_ind();
    test_non_mem_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
